eth_tx_arbiter: RTL and testbench

- Shares the single 64-bit Ethernet TX AXI-Stream between NumIn requester streams, e.g. DMA and a control-frame generator.
- Arbitration is frame-granular round-robin: once an input wins, it keeps the output until its tlast beat completes.
- Software reaches a small register file over the 32-bit reg_bus. It holds the per-input enable mask, a status word and a frame counter.
- Sits between the requesters and the Ethernet MAC TX stream input.

---
 rtl/eth_top_pkg.sv | 46 ++++
 rtl/eth_tx_arbiter_regs.sv | 75 +++++++
 rtl/eth_tx_arbiter.sv | 93 +++++++++
 tb/tb_eth_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_top_pkg.sv
// rtl/eth_top_pkg.sv - shared Ethernet TX stream, register bus and arbiter types
package eth_top_pkg;

    localparam int DataWidth = 64;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic [DataWidth/8-1:0] keep;
        logic                   last;
        logic [0:0]             user;
    } s_beat_t;

    typedef struct packed {
        logic    tvalid;
        s_beat_t t;
    } s_req_t;

    typedef struct packed {
        logic tready;
    } s_rsp_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_bus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        error;
    } reg_bus_rsp_t;

    localparam logic [3:0] ARB_CTRL_OFFS   = 4'h0;
    localparam logic [3:0] ARB_STATUS_OFFS = 4'h4;
    localparam logic [3:0] ARB_FCNT_OFFS   = 4'h8;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/eth_tx_arbiter_regs.sv
// rtl/eth_tx_arbiter_regs.sv - arbiter register file: enable mask, status, frame counter
import eth_top_pkg::*;

module eth_tx_arbiter_regs #(
    parameter int  NumIn = 2,
    localparam int IdxW  = $clog2(NumIn)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  reg_bus_req_t     reg_req_i,
    output reg_bus_rsp_t     reg_rsp_o,
    input  logic             busy,
    input  logic [IdxW-1:0]  grant,
    input  logic [IdxW-1:0]  rr_ptr,
    input  logic             frame_done,
    output logic [NumIn-1:0] enable_mask,
    output logic             fcnt_clr
);

    logic [31:0] frame_cnt;
    logic [31:0] status;
    logic        aligned;
    logic        hit_ctrl;
    logic        hit_status;
    logic        hit_fcnt;
    logic        acc_err;
    logic        wr_ok;

    always_comb begin
        aligned    = (reg_req_i.addr[1:0] == 2'b00);
        hit_ctrl   = aligned && (reg_req_i.addr == ARB_CTRL_OFFS);
        hit_status = aligned && (reg_req_i.addr == ARB_STATUS_OFFS);
        hit_fcnt   = aligned && (reg_req_i.addr == ARB_FCNT_OFFS);
        acc_err    = reg_req_i.valid &&
                     (!(hit_ctrl || hit_status || hit_fcnt) || (hit_status && reg_req_i.write));
        wr_ok      = reg_req_i.valid && reg_req_i.write && !acc_err;
        fcnt_clr   = wr_ok && hit_fcnt;

        status             = '0;
        status[0]          = busy;
        status[8 +: IdxW]  = grant;
        status[16 +: IdxW] = rr_ptr;

        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid;
        reg_rsp_o.error = acc_err;
        if (reg_req_i.valid && !reg_req_i.write && !acc_err) begin
            if (hit_ctrl) begin
                reg_rsp_o.rdata = {{(32-NumIn){1'b0}}, enable_mask};
            end else if (hit_status) begin
                reg_rsp_o.rdata = status;
            end else begin
                reg_rsp_o.rdata = frame_cnt;
            end
        end
    end

    // A counter clear wins over a frame completing in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_mask <= '1;
            frame_cnt   <= '0;
        end else begin
            if (wr_ok && hit_ctrl && reg_req_i.wstrb[0]) begin
                enable_mask <= reg_req_i.wdata[NumIn-1:0];
            end
            if (fcnt_clr) begin
                frame_cnt <= '0;
            end else if (frame_done) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - frame-granular round-robin arbiter onto the Ethernet TX stream
import eth_top_pkg::*;

module eth_tx_arbiter #(
    parameter int  NumIn = 2,
    localparam int IdxW  = $clog2(NumIn)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  s_req_t [NumIn-1:0]   s_axis_req_i,
    output s_rsp_t [NumIn-1:0]   s_axis_rsp_o,
    output s_req_t               m_axis_req_o,
    input  s_rsp_t               m_axis_rsp_i,
    input  reg_bus_req_t         reg_req_i,
    output reg_bus_rsp_t         reg_rsp_o
);

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NumIn-1:0] enable_mask;
    logic [NumIn-1:0] eligible;
    logic             frame_done;
    logic             fcnt_clr;
    logic             found;
    int               idx;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        frame_done   = 1'b0;
        found        = 1'b0;
        idx          = 0;
        m_axis_req_o = '0;
        s_axis_rsp_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            eligible[i] = s_axis_req_i[i].tvalid & enable_mask[i];
        end

        case (state_q)
            ARB_IDLE: begin
                // Search starts at rr_ptr and wraps, so the last winner goes to the back.
                for (int k = 0; k < NumIn; k++) begin
                    idx = (int'(rr_ptr_q) + k) % NumIn;
                    if (!found && eligible[idx]) begin
                        found   = 1'b1;
                        grant_d = IdxW'(idx);
                        state_d = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                m_axis_req_o                  = s_axis_req_i[grant_q];
                s_axis_rsp_o[grant_q].tready  = m_axis_rsp_i.tready;
                frame_done = m_axis_req_o.tvalid & m_axis_rsp_i.tready & m_axis_req_o.t.last;
                if (frame_done) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (int'(grant_q) == NumIn - 1) ? '0 : grant_q + IdxW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    eth_tx_arbiter_regs #(
        .NumIn(NumIn)
    ) u_regs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .reg_req_i   (reg_req_i),
        .reg_rsp_o   (reg_rsp_o),
        .busy        (state_q == ARB_LOCKED),
        .grant       (grant_q),
        .rr_ptr      (rr_ptr_q),
        .frame_done  (frame_done),
        .enable_mask (enable_mask),
        .fcnt_clr    (fcnt_clr)
    );

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - randomized self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;
    import eth_top_pkg::*;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    s_req_t [N-1:0] s_req;
    s_rsp_t [N-1:0] s_rsp;
    s_req_t       m_req;
    s_rsp_t       m_rsp;
    reg_bus_req_t rreq;
    reg_bus_rsp_t rrsp;

    int checks = 0;
    int errors = 0;

    // Reference model: owner=-1 means no input holds the output.
    int          owner;
    int          rr;
    int          last_grant;
    logic [31:0] fcnt;
    logic [N-1:0] mask;
    int          beat [N];
    int          flen [N];
    logic [N-1:0] hold;
    int          pv;
    int          pr;
    logic        frame_end_seen;
    logic        found;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.NumIn(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .s_axis_req_i (s_req),
        .s_axis_rsp_o (s_rsp),
        .m_axis_req_o (m_req),
        .m_axis_rsp_i (m_rsp),
        .reg_req_i    (rreq),
        .reg_rsp_o    (rrsp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        rr = 0;
        last_grant = 0;
        fcnt = '0;
        mask = '1;
        hold = '0;
        for (int i = 0; i < N; i++) begin
            beat[i] = 0;
            flen[i] = 1 + $urandom_range(3);
        end
    endtask

    task automatic drive_streams();
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && ($urandom_range(99) < pv)) begin
                hold[i] = 1'b1;
                s_req[i].t.data = {$urandom, $urandom};
                s_req[i].t.strb = 8'($urandom);
                s_req[i].t.keep = 8'($urandom);
                s_req[i].t.user = 1'($urandom);
            end
            s_req[i].t.last = (beat[i] == flen[i] - 1);
            s_req[i].tvalid = hold[i];
        end
        m_rsp.tready = ($urandom_range(99) < pr);
    endtask

    task automatic check_and_update();
        logic        exp_mv;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] obs_rdy;
        logic        err;
        logic [31:0] exp_rd;
        int          n_owner;
        int          g;
        logic [31:0] n_fcnt;
        logic [N-1:0] n_mask;

        exp_mv = (owner >= 0) ? hold[owner] : 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = (i == owner) && m_rsp.tready;
            obs_rdy[i] = s_rsp[i].tready;
        end
        chk("m_tvalid", m_req.tvalid, exp_mv);
        chk("s_tready", obs_rdy, exp_rdy);
        if (owner >= 0) chk("m_beat", m_req.t, s_req[owner].t);

        err = (rreq.addr[1:0] != 2'b00) || (rreq.addr == 4'hC) ||
              ((rreq.addr == 4'h4) && rreq.write);
        exp_rd = '0;
        if (!err) begin
            if (rreq.addr == 4'h0) exp_rd = 32'(mask);
            else if (rreq.addr == 4'h4) begin
                exp_rd[0]     = (owner >= 0);
                exp_rd[11:8]  = 4'(last_grant);
                exp_rd[19:16] = 4'(rr);
            end else exp_rd = fcnt;
        end
        if (rreq.valid) begin
            chk("reg_ready", rrsp.ready, 1'b1);
            chk("reg_error", rrsp.error, err);
            if (!rreq.write || err) chk("reg_rdata", rrsp.rdata, exp_rd);
        end else begin
            chk("reg_idle", {rrsp.ready, rrsp.error}, 2'b00);
        end

        n_owner = owner;
        n_fcnt = fcnt;
        n_mask = mask;
        frame_end_seen = 1'b0;
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                g = (rr + k) % N;
                if (n_owner < 0 && hold[g] && mask[g]) begin
                    n_owner = g;
                    last_grant = g;
                end
            end
        end else if (hold[owner] && m_rsp.tready) begin
            g = owner;
            hold[g] = 1'b0;
            if (beat[g] == flen[g] - 1) begin
                n_owner = -1;
                rr = (g + 1) % N;
                n_fcnt = fcnt + 32'd1;
                beat[g] = 0;
                flen[g] = 1 + $urandom_range(3);
                frame_end_seen = 1'b1;
            end else begin
                beat[g]++;
            end
        end
        if (rreq.valid && rreq.write && !err) begin
            if (rreq.addr == 4'h0 && rreq.wstrb[0]) n_mask = rreq.wdata[N-1:0];
            if (rreq.addr == 4'h8) n_fcnt = '0;
        end
        owner = n_owner;
        fcnt = n_fcnt;
        mask = n_mask;
    endtask

    task automatic step();
        drive_streams();
        #1;
        check_and_update();
        @(posedge clk);
        #1;
        rreq = '0;
    endtask

    task automatic reg_op(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        rreq.valid = 1'b1;
        rreq.write = wr;
        rreq.addr  = a;
        rreq.wdata = d;
        rreq.wstrb = s;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rreq = '0;
        s_req = '0;
        m_rsp = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pv = 0;
        pr = 100;
        rreq = '0;
        s_req = '0;
        m_rsp = '0;
        model_reset();
        #1;
        chk("rst_m_tvalid", m_req.tvalid, 1'b0);
        chk("rst_s_tready", {s_rsp[1].tready, s_rsp[0].tready}, 2'b00);
        chk("rst_reg_rsp", {rrsp.ready, rrsp.error}, 2'b00);
        do_reset();
        reg_op(1'b0, 4'h0, 32'h0, 4'h0);
        reg_op(1'b0, 4'h4, 32'h0, 4'h0);
        reg_op(1'b0, 4'h8, 32'h0, 4'h0);

        // random traffic with random register accesses
        pv = 60;
        pr = 70;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(3) == 0) begin
                rreq.valid = 1'b1;
                rreq.write = ($urandom_range(3) == 0);
                rreq.addr  = 4'($urandom);
                rreq.wdata = $urandom | 32'h1;
                rreq.wstrb = 4'($urandom);
            end
            step();
        end

        // fairness: both inputs always valid, no backpressure
        reg_op(1'b1, 4'h0, 32'h3, 4'h1);
        pv = 100;
        pr = 100;
        for (int c = 0; c < 80; c++) step();
        reg_op(1'b0, 4'h8, 32'h0, 4'h0);

        // backpressure: alternating tready
        for (int c = 0; c < 60; c++) begin
            pr = (c % 2 == 0) ? 100 : 0;
            step();
        end

        // mask input 1 off while it is mid-frame
        pr = 70;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            if (owner == 1 && beat[1] > 0) found = 1'b1;
            else step();
        end
        chk("mask_target_reached", found, 1'b1);
        reg_op(1'b1, 4'h0, 32'hFFFF_FFF1, 4'h1);
        for (int c = 0; c < 60; c++) step();
        reg_op(1'b0, 4'h0, 32'h0, 4'h0);

        // empty mask: nothing may be granted
        reg_op(1'b1, 4'h0, 32'h0, 4'hF);
        for (int c = 0; c < 40; c++) step();
        chk("empty_mask_idle", owner, -1);

        // error accesses
        reg_op(1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF);
        reg_op(1'b0, 4'h4, 32'h0, 4'h0);
        reg_op(1'b0, 4'hC, 32'h0, 4'h0);
        reg_op(1'b1, 4'hC, 32'h1, 4'hF);
        reg_op(1'b1, 4'h2, 32'h3, 4'hF);
        reg_op(1'b0, 4'h1, 32'h0, 4'h0);
        reg_op(1'b1, 4'h0, 32'h3, 4'hE);
        reg_op(1'b0, 4'h0, 32'h0, 4'h0);
        reg_op(1'b1, 4'h0, 32'h3, 4'h1);
        reg_op(1'b0, 4'h0, 32'h0, 4'h0);

        // counter clear coincident with a frame end
        pv = 100;
        pr = 100;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (owner >= 0 && beat[owner] == flen[owner] - 1) begin
                found = 1'b1;
                rreq.valid = 1'b1;
                rreq.write = 1'b1;
                rreq.addr  = 4'h8;
                rreq.wdata = $urandom;
                rreq.wstrb = 4'($urandom);
            end
            step();
        end
        chk("clear_frame_end_coincide", {found, frame_end_seen}, 2'b11);
        reg_op(1'b0, 4'h8, 32'h0, 4'h0);

        // reset during beat 2 of a 4-beat frame
        do_reset();
        pv = 0;
        reg_op(1'b1, 4'h0, 32'h1, 4'h1);
        pv = 100;
        flen[0] = 4;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (owner == 0 && beat[0] == 1) found = 1'b1;
            else step();
        end
        chk("reset_target_reached", found, 1'b1);
        drive_streams();
        #1;
        chk("pre_reset_m_tvalid", m_req.tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_m_tvalid", m_req.tvalid, 1'b0);
        chk("mid_reset_s_tready", {s_rsp[1].tready, s_rsp[0].tready}, 2'b00);
        do_reset();
        pv = 0;
        reg_op(1'b0, 4'h0, 32'h0, 4'h0);
        reg_op(1'b0, 4'h8, 32'h0, 4'h0);
        reg_op(1'b0, 4'h4, 32'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
